act_share_ctrl: RTL and testbench
=================================

# act_share_ctrl

Round-robin scheduler that shares one pipelined Q16.16 tanh unit (1024-entry LUT plus linear interpolation, fixed latency) between `N_REQ` requesters, such as LSTM/GRU gate lanes. Sigmoid is computed through the same unit as sigmoid(x) = (tanh(x/2)+1)/2. The block applies the pre-shift on issue and the post-shift/offset on return. It tags each issue, steers each result back to its owner, and holds it in a per-requester response register until accepted.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `FIXED`, 32: datapath width, Q16.16 signed.
- `LAT`, 2: cycles from `act_valid` to `act_res` valid in the shared unit (1..8).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: per-requester request.
- `req_ready` out N_REQ: one-hot grant; handshake when valid&&ready.
- `req_func` in N_REQ: 0 = tanh, 1 = sigmoid.
- `req_data` in N_REQ*FIXED: operand x; lane i is bits [i*FIXED +: FIXED].
- `rsp_valid` out N_REQ: result held for lane i.
- `rsp_ready` in N_REQ: lane i accepts its result.
- `rsp_data` out N_REQ*FIXED: result; lane layout matches `req_data`.
- `act_valid` out 1: issue strobe to the shared tanh unit.
- `act_x` out FIXED: operand to the shared unit.
- `act_res` in FIXED: unit result, valid exactly LAT cycles after `act_valid`.
- `idle` out 1: high when no lane is busy and the tag pipe is empty.

## Operation
- Per-lane `busy[i]`:
  - Set on the request handshake.
  - Cleared on the response handshake (`rsp_valid[i] && rsp_ready[i]`).
  - Each lane has at most one operation outstanding, so response registers never overflow.
- Eligibility: `req_valid[i] && !busy[i]`, using the registered busy value.
  - A lane whose busy bit clears in cycle t first becomes eligible in cycle t+1.
- Arbitration:
  - Round-robin over eligible lanes, starting at pointer `rr_ptr`.
  - The first eligible lane at or after `rr_ptr` (modulo N_REQ) is granted.
  - At most one grant per cycle.
  - After a grant to lane g, `rr_ptr` becomes (g+1) mod N_REQ. With no grant, it holds.
  - `req_ready` is combinational from eligibility and `rr_ptr`. It is zero for ineligible lanes.
- Issue register, loaded on a grant:
  - `act_valid` <= 1.
  - Tanh: `act_x` <= x.
  - Sigmoid: `act_x` <= {x[31], x[31:1]} (arithmetic shift right by 1).
  - With no grant, `act_valid` <= 0 and `act_x` holds.
- Tag pipe: LAT+1 stages of {valid, lane index (clog2 N_REQ bits), func}, aligned so the tag exits with `act_res`.
- Return path, when the tag exits valid:
  - Compute r' for tanh: r' = r.
  - Compute r' for sigmoid: r' = {r[31], r[31:1]} + 32'h0000_8000, with a wrapping 32-bit add.
  - Write r' into `rsp_data[lane]` and set `rsp_valid[lane]`.
- Response hold:
  - `rsp_valid[i]` stays high and `rsp_data[i]` stays stable until the handshake.
  - `rsp_valid[i]` clears the cycle after the handshake.
- Saturation for |x| ≥ 4 is the shared unit's job. The controller never alters `act_res` beyond the sigmoid post-step.

## Timing
- Reset (asynchronous, `rst_n` low) clears or sets:
  - `busy`, `rr_ptr`, all tag valids: 0.
  - `act_valid`, `act_x`: 0.
  - `rsp_valid`, `rsp_data`: 0.
  - `req_ready`: 0 while `rst_n` is low.
  - `idle`: 1.
- Reset asserted mid-operation drops all in-flight work. Results arriving after reset release are ignored because their tags were cleared.
- Cycle-level timeline:
  - Handshake in cycle t.
  - `act_valid` high in cycle t+1.
  - `act_res` sampled in cycle t+1+LAT.
  - `rsp_valid` high from cycle t+2+LAT.
  - Request-to-response latency is LAT+2 cycles.
- Throughput: one issue per cycle aggregate. A single lane that accepts its response in the same cycle `rsp_valid` rises issues at most once per LAT+3 cycles.
- Simultaneous events:
  - A response handshake and a new `req_valid` on the same lane in the same cycle: no grant that cycle; the grant comes next cycle.
  - Results for different lanes completing in consecutive cycles are all captured; there is one write per cycle maximum.
- `idle` is registered: it equals ~|busy && no valid tag, as of the previous edge.

## Test plan
Bench stub for the shared unit: `act_res` = `act_x` delayed by LAT (echo).
- Tanh pass-through: lane 0 sends tanh with x=0x0001_8000 -> `act_x`=0x0001_8000 at t+1; `rsp_data[0]`=0x0001_8000 with `rsp_valid[0]` at t+LAT+2.
- Sigmoid arithmetic:
  - Sigmoid, x=0x0002_0000 -> `act_x`=0x0001_0000 and response 0x0001_0000.
  - Sigmoid, x=0xFFFE_0000 -> `act_x`=0xFFFF_0000 and response 0x0000_0000.
  - Sigmoid, x=0 -> response 0x0000_8000.
- Round-robin fairness: all 4 lanes hold `req_valid` from reset with `rsp_ready`=1 -> grants go 0,1,2,3 in consecutive cycles, then the order repeats 0,1,2,3 as busy bits clear; no lane is granted twice before every other eligible lane.
- Response hold and backpressure:
  - Lane 2 holds `rsp_ready`=0 for 10 cycles -> `rsp_valid[2]` and its data stay stable.
  - Lane 2 gets no second grant while its result is held.
  - Other lanes keep issuing.
- Same-cycle release: lane 1 response handshake coincides with a new `req_valid[1]` -> `req_ready[1]`=0 that cycle and 1 in the next cycle (if `rr_ptr` permits).
- Reset mid-flight: assert `rst_n`=0 one cycle after three grants -> all outputs are at reset values, no `rsp_valid` appears after release, and `idle`=1.

Source files
------------

// File: rtl/act_share_ctrl_if.sv
// Requester-side bundle for act_share_ctrl: request handshake with operand and
// function select, plus the per-lane held response handshake.
interface act_share_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int FIXED = 32
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       req_func;
  logic [N_REQ*FIXED-1:0] req_data;
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ready;
  logic [N_REQ*FIXED-1:0] rsp_data;

  // Requesters drive operands and accept results.
  modport master (
    output req_valid, req_func, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  // The controller grants requests and holds results.
  modport slave (
    input  req_valid, req_func, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/act_share_ctrl.sv
// Round-robin sharing of one pipelined Q16.16 tanh unit between N_REQ lanes.
// Sigmoid reuses the unit as (tanh(x/2)+1)/2: halve on issue, halve and add
// 0.5 on return. A tag pipe matched to the unit latency steers each result
// back into its owner's response register, where it is held until accepted.
module act_share_ctrl #(
  parameter int N_REQ = 4,
  parameter int FIXED = 32,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  act_share_ctrl_if.slave  req,
  output logic             act_valid,
  output logic [FIXED-1:0] act_x,
  input  logic [FIXED-1:0] act_res,
  output logic             idle
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IW:0] NREQ_W = (IW+1)'(N_REQ);
  localparam logic [FIXED-1:0] HALF = {{(FIXED-1){1'b0}}, 1'b1} << (FIXED/2 - 1);

  logic [N_REQ-1:0]       busy;
  logic [IW-1:0]          rr_ptr;
  logic [N_REQ-1:0]       elig;
  logic [N_REQ-1:0]       grant;
  logic                   grant_any;
  logic [IW-1:0]          grant_idx;
  logic [IW:0]            scan;
  logic [FIXED-1:0]       sel_x;
  logic                   sel_func;
  logic [LAT:0]           tag_v;
  logic [IW-1:0]          tag_lane [0:LAT];
  logic [LAT:0]           tag_func;
  logic [FIXED-1:0]       ret_data;
  logic [N_REQ-1:0]       rsp_valid_q;
  logic [N_REQ*FIXED-1:0] rsp_data_q;
  logic [N_REQ-1:0]       rsp_hs;

  assign elig          = req.req_valid & ~busy;
  assign rsp_hs        = rsp_valid_q & req.rsp_ready;
  assign req.req_ready = grant & {N_REQ{rst_n}};
  assign req.rsp_valid = rsp_valid_q;
  assign req.rsp_data  = rsp_data_q;

  // Pick the first eligible lane at or after rr_ptr, wrapping around.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (IW+1)'(k);
      if (scan >= NREQ_W) scan = scan - NREQ_W;
      if (!grant_any && elig[scan[IW-1:0]]) begin
        grant_any               = 1'b1;
        grant_idx               = scan[IW-1:0];
        grant[scan[IW-1:0]]     = 1'b1;
      end
    end
  end

  // Route the granted lane's operand and function select toward the issue stage.
  always_comb begin
    sel_x    = '0;
    sel_func = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IW'(i)) begin
        sel_x    = req.req_data[i*FIXED +: FIXED];
        sel_func = req.req_func[i];
      end
    end
  end

  // Lane occupancy and the round-robin pointer advance past each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= '0;
      rr_ptr <= '0;
    end else begin
      busy <= (busy | grant) & ~rsp_hs;
      if (grant_any)
        rr_ptr <= (grant_idx == IW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Issue register: sigmoid operands are halved before entering the unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_valid <= 1'b0;
      act_x     <= '0;
    end else begin
      act_valid <= grant_any;
      if (grant_any)
        act_x <= sel_func ? {sel_x[FIXED-1], sel_x[FIXED-1:1]} : sel_x;
    end
  end

  // Tag pipe: one stage more than the unit latency so the tag exits with act_res.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v    <= '0;
      tag_func <= '0;
      for (int i = 0; i <= LAT; i++) tag_lane[i] <= '0;
    end else begin
      tag_v       <= {tag_v[LAT-1:0], grant_any};
      tag_func    <= {tag_func[LAT-1:0], sel_func};
      tag_lane[0] <= grant_idx;
      for (int i = 1; i <= LAT; i++) tag_lane[i] <= tag_lane[i-1];
    end
  end

  // Sigmoid post-step: halve the tanh result and add 0.5, wrapping.
  always_comb begin
    ret_data = act_res;
    if (tag_func[LAT])
      ret_data = {act_res[FIXED-1], act_res[FIXED-1:1]} + HALF;
  end

  // Per-lane response registers hold their result until the lane accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (tag_v[LAT] && tag_lane[LAT] == IW'(i)) begin
          rsp_valid_q[i]              <= 1'b1;
          rsp_data_q[i*FIXED +: FIXED] <= ret_data;
        end else if (rsp_hs[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  // Idle reflects the previous cycle's occupancy and tag pipe contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle <= 1'b1;
    else
      idle <= ~|busy && ~|tag_v;
  end

endmodule

// File: tb/tb_act_share_ctrl.sv
// Scoreboard bench for act_share_ctrl with an echo stand-in for the tanh unit.
module tb_act_share_ctrl;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          act_valid;
  logic [W-1:0]  act_x;
  logic [W-1:0]  act_res;
  logic          idle;
  logic [W-1:0]  echo [0:LAT-1];

  int checkCount = 0;
  int passCount  = 0;
  int cyc = 0;
  bit monOn = 1'b0;

  logic [N-1:0]  busyM;
  int            ptrM;
  logic [N-1:0]  prevRspV;
  int            grantCyc [N];
  logic [W-1:0]  actQ [$];
  logic [W-1:0]  rspQ [N][$];
  int            grantLog [$];
  int            grantCycLog [$];

  act_share_ctrl_if #(.N_REQ(N), .FIXED(W)) bus ();

  act_share_ctrl #(.N_REQ(N), .FIXED(W), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus),
    .act_valid (act_valid),
    .act_x     (act_x),
    .act_res   (act_res),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency and spacing checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Echo unit: act_res is act_x delayed by LAT cycles.
  always @(posedge clk) begin
    echo[0] <= act_x;
    for (int i = 1; i < LAT; i++) echo[i] <= echo[i-1];
  end
  assign act_res = echo[LAT-1];

  function automatic logic [W-1:0] modelAct(input logic f, input logic [W-1:0] x);
    return f ? W'($signed(x) >>> 1) : x;
  endfunction

  function automatic logic [W-1:0] modelRsp(input logic f, input logic [W-1:0] x);
    logic [W-1:0] r;
    r = modelAct(f, x);
    return f ? W'($signed(r) >>> 1) + 32'h0000_8000 : r;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] rdy, input int cycles);
    bus.req_valid = valid;
    bus.rsp_ready = rdy;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDrain(input int budget);
    int c;
    c = 0;
    while ((busyM != '0 || actQ.size() != 0) && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    checkOutput("drain", W'(busyM), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("idle_after_drain", W'(idle), 1);
  endtask

  // Monitor: reference arbiter, issue and response scoreboard.
  always @(negedge clk) begin
    logic [N-1:0] expReady;
    logic [N-1:0] hs;
    int idx;
    int g;
    if (!rst_n) begin
      busyM    = '0;
      ptrM     = 0;
      prevRspV = '0;
      actQ.delete();
      for (int i = 0; i < N; i++) rspQ[i].delete();
    end else if (monOn) begin
      checkOutput("act_valid", W'(act_valid), W'(actQ.size() != 0));
      if (act_valid && actQ.size() != 0) checkOutput("act_x", act_x, actQ.pop_front());

      expReady = '0;
      for (int k = 0; k < N; k++) begin
        idx = (ptrM + k) % N;
        if (expReady == '0 && bus.req_valid[idx] && !busyM[idx]) expReady[idx] = 1'b1;
      end
      checkOutput("req_ready", W'(bus.req_ready), W'(expReady));

      for (int i = 0; i < N; i++) begin
        if (bus.rsp_valid[i]) begin
          if (rspQ[i].size() == 0) begin
            checkOutput("rsp_unexpected", W'(i), W'(N));
          end else begin
            checkOutput("rsp_data", bus.rsp_data[i*W +: W], rspQ[i][0]);
            if (!prevRspV[i]) checkOutput("rsp_latency", W'(cyc - grantCyc[i]), W'(LAT + 2));
            if (bus.rsp_ready[i]) begin
              void'(rspQ[i].pop_front());
              busyM[i] = 1'b0;
            end
          end
        end
      end
      prevRspV = bus.rsp_valid;

      hs = bus.req_ready & bus.req_valid;
      if (hs != '0) begin
        g = 0;
        for (int i = 0; i < N; i++) if (hs[i]) g = i;
        actQ.push_back(modelAct(bus.req_func[g], bus.req_data[g*W +: W]));
        rspQ[g].push_back(modelRsp(bus.req_func[g], bus.req_data[g*W +: W]));
        busyM[g] = 1'b1;
        ptrM = (g + 1) % N;
        grantCyc[g] = cyc;
        grantLog.push_back(g);
        grantCycLog.push_back(cyc);
      end
    end
  end

  initial begin
    int cnt;
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    bus.req_func  = 4'b1110;
    bus.req_data  = {32'h0000_0000, 32'hFFFE_0000, 32'h0002_0000, 32'h0001_8000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", W'(bus.req_ready), 0);
    checkOutput("rst_act_valid", W'(act_valid), 0);
    checkOutput("rst_act_x", act_x, 0);
    checkOutput("rst_rsp_valid", W'(bus.rsp_valid), 0);
    checkOutput("rst_rsp_data_l0", bus.rsp_data[31:0], 0);
    checkOutput("rst_idle", W'(idle), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    monOn = 1'b1;

    $display("[TB] round-robin fairness with mixed tanh/sigmoid lanes");
    applyStimulus(4'hF, 4'hF, 5);
    checkOutput("idle_busy", W'(idle), 0);
    applyStimulus(4'hF, 4'hF, 15);
    applyStimulus(4'h0, 4'hF, 0);
    waitDrain(40);
    checkOutput("rr_count", W'(grantLog.size() >= 8), 1);
    for (int i = 0; i < 8 && i < grantLog.size(); i++) checkOutput("rr_order", W'(grantLog[i]), W'(i % 4));
    if (grantCycLog.size() >= 4) checkOutput("rr_consecutive", W'(grantCycLog[3] - grantCycLog[0]), 3);

    $display("[TB] backpressure on lane 2");
    grantLog.delete();
    grantCycLog.delete();
    applyStimulus(4'hF, 4'b1011, 20);
    checkOutput("bp_held", W'(bus.rsp_valid[2]), 1);
    cnt = 0;
    foreach (grantLog[i]) if (grantLog[i] == 2) cnt++;
    checkOutput("bp_lane2_grants", W'(cnt), 1);
    cnt = 0;
    foreach (grantLog[i]) if (grantLog[i] == 0) cnt++;
    checkOutput("bp_others_issue", W'(cnt >= 2), 1);
    applyStimulus(4'h0, 4'hF, 1);
    waitDrain(40);

    $display("[TB] same-cycle release on lane 1");
    grantLog.delete();
    grantCycLog.delete();
    applyStimulus(4'b0010, 4'hF, 16);
    applyStimulus(4'h0, 4'hF, 0);
    waitDrain(40);
    checkOutput("rel_count", W'(grantCycLog.size() >= 2), 1);
    for (int i = 1; i < grantCycLog.size(); i++)
      checkOutput("rel_gap", W'(grantCycLog[i] - grantCycLog[i-1]), W'(LAT + 3));

    $display("[TB] reset mid-flight");
    grantLog.delete();
    grantCycLog.delete();
    bus.req_valid = 4'hF;
    for (int c = 0; c < 40 && grantLog.size() < 3; c++) @(negedge clk);
    checkOutput("mid_grants", W'(grantLog.size() >= 3), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_req_ready", W'(bus.req_ready), 0);
    checkOutput("mid_act_valid", W'(act_valid), 0);
    checkOutput("mid_act_x", act_x, 0);
    checkOutput("mid_rsp_valid", W'(bus.rsp_valid), 0);
    checkOutput("mid_rsp_data", bus.rsp_data[127:96] | bus.rsp_data[95:64] | bus.rsp_data[63:32] | bus.rsp_data[31:0], 0);
    checkOutput("mid_idle", W'(idle), 1);
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(4'h0, 4'hF, 12);
    checkOutput("post_rst_rsp_valid", W'(bus.rsp_valid), 0);
    checkOutput("post_rst_idle", W'(idle), 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
